alu_display_scan: RTL

ALU_DISPLAY_SCAN -- requirements
Module: alu_display_scan

---
 rtl/alu_display_scan.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_display_scan.sv
// alu_display_scan: scans four {A,B,opcode} slots through one shared 4-bit ALU and
// one hex-to-7-segment decoder onto a 4-digit, one-hot, active-high display.
// Optional macro DISPLAY_BLANK_EN adds a dark BLANK cycle after each digit.
module alu_display_scan #(
    parameter int DWELL = 4                 // cycles each digit stays lit, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load_valid,
    input  logic [1:0] load_slot,
    input  logic [3:0] load_A,
    input  logic [3:0] load_B,
    input  logic [1:0] load_opcode,
    output logic       load_ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic [3:0] an,
    output logic [1:0] cur_slot
);

    typedef struct packed {
        logic [3:0] op_a;
        logic [3:0] op_b;
        logic [1:0] opcode;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SHOW    = 2'd2
`ifdef DISPLAY_BLANK_EN
        , BLANK = 2'd3
`endif
    } state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t     state_q;
    slot_t      slot_q [4];
    logic [1:0] cur_slot_q;
    logic [3:0] result_q;
    logic [7:0] dwell_q;
    logic [3:0] an_q;
    logic       lit_q;
    slot_t      cur_s;
    logic [3:0] alu_res;
    logic [6:0] seg;

    // Segment pattern {a..g} for one hex digit.
    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Writes collide only with the slot whose result is being captured this cycle.
    assign load_ready = !((state_q == COMPUTE) && (load_slot == cur_slot_q));

    // Shared ALU operating on the slot currently being sequenced; results wrap at 4 bits.
    always_comb begin
        cur_s   = slot_q[cur_slot_q];
        alu_res = '0;
        case (cur_s.opcode)
            2'b00:   alu_res = cur_s.op_a + cur_s.op_b;
            2'b01:   alu_res = cur_s.op_a - cur_s.op_b;
            2'b10:   alu_res = cur_s.op_a & cur_s.op_b;
            default: alu_res = cur_s.op_a | cur_s.op_b;
        endcase
    end

    // Slot register file; any accepted write lands at the next edge regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
        end else if (load_valid && load_ready) begin
            slot_q[load_slot] <= '{op_a: load_A, op_b: load_B, opcode: load_opcode};
        end
    end

    // Scan FSM: capture result in COMPUTE, hold the digit for DWELL cycles, advance slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_slot_q <= '0;
            result_q   <= '0;
            dwell_q    <= '0;
            an_q       <= '0;
            lit_q      <= 1'b0;
        end else if (!enable) begin
            state_q    <= IDLE;
            cur_slot_q <= '0;
            dwell_q    <= '0;
            an_q       <= '0;
            lit_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    result_q <= alu_res;
                    an_q     <= 4'(4'b0001 << cur_slot_q);
                    lit_q    <= 1'b1;
                    dwell_q  <= DWELL_M1;
                    state_q  <= SHOW;
                end
                SHOW: begin
                    if (dwell_q != 8'd0) begin
                        dwell_q <= dwell_q - 8'd1;
                    end else begin
                        an_q  <= '0;
                        lit_q <= 1'b0;
`ifdef DISPLAY_BLANK_EN
                        state_q <= BLANK;
`else
                        cur_slot_q <= cur_slot_q + 2'd1;
                        state_q    <= COMPUTE;
`endif
                    end
                end
`ifdef DISPLAY_BLANK_EN
                BLANK: begin
                    cur_slot_q <= cur_slot_q + 2'd1;
                    state_q    <= COMPUTE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    an_q    <= '0;
                    lit_q   <= 1'b0;
                end
            endcase
        end
    end

    // Segments come only from registered state, dark whenever no digit is selected.
    assign seg = lit_q ? hex7seg(result_q) : 7'h00;
    assign {a, b, c, d, e, f, g} = seg;
    assign an       = an_q;
    assign cur_slot = cur_slot_q;

endmodule
